// File: rtl/lock_pkg.sv
// Shared encodings and defaults for the keypad lock sequencer and its blink requester.
package lock_pkg;

  localparam int unsigned DEF_CODE_LEN = 4;
  localparam int unsigned DEF_DIGIT_W  = 2;
  localparam int unsigned CODE_W       = DEF_CODE_LEN * DEF_DIGIT_W;

  localparam logic BLINK_ERROR   = 1'b0;
  localparam logic BLINK_SUCCESS = 1'b1;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_PROGRAM,
    S_BLINK,
    S_LOCKOUT
  } main_state_e;

  typedef enum logic [2:0] {
    B_IDLE,
    B_SETUP,
    B_ARM,
    B_WAIT,
    B_RELEASE
  } blink_state_e;

endpackage

// File: rtl/lock_blink_controller_if.sv
// Initiator/target handshake between the lock sequencer and the LED blinker.
interface lock_blink_controller_if;
  logic start_blinking;
  logic blinkType;
  logic done_blinking;

  modport master (output start_blinking, output blinkType, input  done_blinking);
  modport slave  (input  start_blinking, input  blinkType, output done_blinking);
endinterface

// File: rtl/blink_requester.sv
// Runs one start/done handshake with the blinker per req pulse, with a done timeout.
module blink_requester
  import lock_pkg::*;
#(
  parameter logic [31:0] DONE_TIMEOUT = 32'd48000000
) (
  input  logic hwclk,
  input  logic rst,
  input  logic req,
  input  logic req_type,
  input  logic done_blinking,
  output logic start_blinking,
  output logic blinkType,
  output logic ack,
  output logic timeout
);

  blink_state_e state_q, state_d;
  logic         start_q, start_d;
  logic         type_q, type_d;
  logic [31:0]  timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    type_d  = type_q;
    timeout = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (req) begin
          state_d = B_SETUP;
          type_d  = req_type;
        end
      end
      B_SETUP: begin
        state_d = B_ARM;
        start_d = 1'b1;
      end
      // done is stale right after the start edge, so first wait for it to drop
      B_ARM: begin
        if (timer_q == DONE_TIMEOUT) begin
          timeout = 1'b1;
          state_d = B_RELEASE;
          start_d = 1'b0;
        end else if (!done_blinking) begin
          state_d = B_WAIT;
        end
      end
      B_WAIT: begin
        if (done_blinking) begin
          state_d = B_RELEASE;
          start_d = 1'b0;
        end else if (timer_q == DONE_TIMEOUT) begin
          timeout = 1'b1;
          state_d = B_RELEASE;
          start_d = 1'b0;
        end
      end
      B_RELEASE: state_d = B_IDLE;
      default:   state_d = B_IDLE;
    endcase

    if (state_d != state_q || !(state_q == B_ARM || state_q == B_WAIT)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= B_IDLE;
      start_q <= 1'b0;
      type_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      type_q  <= type_d;
      timer_q <= timer_d;
    end
  end

  assign start_blinking = start_q;
  assign blinkType      = type_q;
  assign ack            = (state_q == B_RELEASE);

endmodule

// File: rtl/lock_blink_controller.sv
// Keypad lock: collects digits, checks/reprograms the code, drives success/error blinks, locks out after repeated failures.
module lock_blink_controller
  import lock_pkg::*;
#(
  parameter int unsigned                 CODE_LEN       = DEF_CODE_LEN,
  parameter int unsigned                 DIGIT_W        = DEF_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE     = 8'b00_01_10_11,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter logic [31:0]                 LOCKOUT_CYCLES = 32'd120000000,
  parameter logic [31:0]                 DONE_TIMEOUT   = 32'd48000000
) (
  input  logic                         hwclk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [DIGIT_W-1:0]           key_code,
  input  logic                         prog_req,
  input  logic                         lock_req,
  lock_blink_controller_if.master      blink,
  output logic                         unlocked,
  output logic                         programming,
  output logic                         busy,
  output logic [1:0]                   fail_count,
  output logic                         timeout_err
);

  localparam int unsigned CW    = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(CODE_LEN);
  localparam logic [1:0]       FAIL_LIMIT = 2'(MAX_FAILS);

  main_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CW-1:0]    entry_q, entry_d;
  logic [CW-1:0]    code_q, code_d;
  logic             unlocked_q, unlocked_d;
  logic             programming_q, programming_d;
  logic             busy_q, busy_d;
  logic [1:0]       fail_q, fail_d;
  logic             timeout_err_q, timeout_err_d;
  logic [31:0]      lock_timer_q, lock_timer_d;

  logic blink_req, blink_req_type, blink_ack, blink_timeout;

  blink_requester #(
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) u_req (
    .hwclk          (hwclk),
    .rst            (rst),
    .req            (blink_req),
    .req_type       (blink_req_type),
    .done_blinking  (blink.done_blinking),
    .start_blinking (blink.start_blinking),
    .blinkType      (blink.blinkType),
    .ack            (blink_ack),
    .timeout        (blink_timeout)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    entry_d        = entry_q;
    code_d         = code_q;
    unlocked_d     = unlocked_q;
    programming_d  = programming_q;
    fail_d         = fail_q;
    lock_timer_d   = lock_timer_q + 32'd1;
    timeout_err_d  = timeout_err_q | blink_timeout;
    blink_req      = 1'b0;
    blink_req_type = BLINK_ERROR;

    case (state_q)
      S_LOCKED: begin
        if (count_q == COUNT_FULL) begin
          count_d   = '0;
          blink_req = 1'b1;
          state_d   = S_BLINK;
          if (entry_q == code_q) begin
            unlocked_d     = 1'b1;
            fail_d         = '0;
            blink_req_type = BLINK_SUCCESS;
          end else begin
            fail_d = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
          end
        end else if (key_valid) begin
          // collection always starts at count 0, so shifting in from the top lands digit i at index i
          entry_d = {key_code, entry_q[CW-1:DIGIT_W]};
          count_d = count_q + CNT_W'(1);
        end
      end
      S_BLINK: begin
        if (blink_ack) begin
          if (unlocked_q)                state_d = S_UNLOCKED;
          else if (fail_q == FAIL_LIMIT) state_d = S_LOCKOUT;
          else                           state_d = S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        if (lock_timer_q == LOCKOUT_CYCLES - 32'd1) begin
          fail_d  = '0;
          state_d = S_LOCKED;
        end
      end
      S_UNLOCKED: begin
        if (lock_req) begin
          unlocked_d = 1'b0;
          count_d    = '0;
          state_d    = S_LOCKED;
        end else if (prog_req) begin
          programming_d = 1'b1;
          count_d       = '0;
          state_d       = S_PROGRAM;
        end
      end
      S_PROGRAM: begin
        if (lock_req) begin
          programming_d = 1'b0;
          unlocked_d    = 1'b0;
          count_d       = '0;
          state_d       = S_LOCKED;
        end else if (count_q == COUNT_FULL) begin
          code_d         = entry_q;
          programming_d  = 1'b0;
          count_d        = '0;
          blink_req      = 1'b1;
          blink_req_type = BLINK_SUCCESS;
          state_d        = S_BLINK;
        end else if (key_valid) begin
          entry_d = {key_code, entry_q[CW-1:DIGIT_W]};
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = S_LOCKED;
    endcase

    if (state_d != state_q) lock_timer_d = '0;
    busy_d = (state_d == S_BLINK) || (state_d == S_LOCKOUT);
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q       <= S_LOCKED;
      count_q       <= '0;
      entry_q       <= '0;
      code_q        <= RESET_CODE;
      unlocked_q    <= 1'b0;
      programming_q <= 1'b0;
      busy_q        <= 1'b0;
      fail_q        <= '0;
      timeout_err_q <= 1'b0;
      lock_timer_q  <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      entry_q       <= entry_d;
      code_q        <= code_d;
      unlocked_q    <= unlocked_d;
      programming_q <= programming_d;
      busy_q        <= busy_d;
      fail_q        <= fail_d;
      timeout_err_q <= timeout_err_d;
      lock_timer_q  <= lock_timer_d;
    end
  end

  assign unlocked    = unlocked_q;
  assign programming = programming_q;
  assign busy        = busy_q;
  assign fail_count  = fail_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lock_blink_controller.sv
// Directed bench for lock_blink_controller with a behavioural LED blinker.
module tb_lock_blink_controller;

  logic       hwclk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_code = 2'd0;
  logic       prog_req = 1'b0;
  logic       lock_req = 1'b0;
  logic       unlocked, programming, busy, timeout_err;
  logic [1:0] fail_count;

  lock_blink_controller_if bif ();

  lock_blink_controller #(
    .LOCKOUT_CYCLES (32'd100),
    .DONE_TIMEOUT   (32'd50)
  ) dut (
    .hwclk       (hwclk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .prog_req    (prog_req),
    .lock_req    (lock_req),
    .blink       (bif.master),
    .unlocked    (unlocked),
    .programming (programming),
    .busy        (busy),
    .fail_count  (fail_count),
    .timeout_err (timeout_err)
  );

  always #5 hwclk = ~hwclk;

  // Blinker: done drops one cycle after start rises, returns high 20 cycles later.
  logic stuck = 1'b0;
  logic start_prev;
  int   bcnt;
  always @(posedge hwclk) begin
    if (rst) begin
      bif.done_blinking <= 1'b1;
      start_prev        <= 1'b0;
      bcnt              <= 0;
    end else begin
      start_prev <= bif.start_blinking;
      if (stuck) begin
        bif.done_blinking <= 1'b1;
      end else if (bif.start_blinking && !start_prev) begin
        bif.done_blinking <= 1'b0;
        bcnt              <= 20;
      end else if (bcnt > 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) bif.done_blinking <= 1'b1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [1:0] d);
    key_valid = 1'b1;
    key_code  = d;
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [7:0] code);
    for (int d = 0; d < 4; d++) press(code[2*d +: 2]);
  endtask

  task automatic pulse_lock();
    lock_req = 1'b1;
    @(negedge hwclk);
    lock_req = 1'b0;
  endtask

  // Follows one handshake, returning at the release sample; ncyc = samples with start high.
  task automatic run_blink(input logic exp_type, input logic inject, input logic normal, output int ncyc);
    int   n;
    logic p1, p2, type_ok;
    n = 0;
    while (!busy && n < 8) begin
      @(negedge hwclk);
      n++;
    end
    check("busy_rise", busy, 1);
    check("setup_type", bif.blinkType, exp_type);
    check("setup_start", bif.start_blinking, 0);
    @(negedge hwclk);
    check("arm_start", bif.start_blinking, 1);
    ncyc = 1; type_ok = 1'b1; p1 = 1'b0; p2 = 1'b0;
    while (ncyc < 400) begin
      p2 = p1;
      p1 = bif.done_blinking;
      if (inject && ncyc == 4) begin
        key_valid = 1'b1;
        key_code  = 2'd3;
      end
      @(negedge hwclk);
      key_valid = 1'b0;
      if (!bif.start_blinking) break;
      ncyc++;
      if (bif.blinkType !== exp_type || !busy) type_ok = 1'b0;
    end
    check("start_fall", bif.start_blinking, 0);
    check("hold_type_busy", type_ok, 1);
    check("release_busy", busy, 1);
    check("release_type", bif.blinkType, exp_type);
    if (normal) check("done_to_fall", {p2, p1}, 2'b01);
  endtask

  localparam logic [1:0] OP_CODE = 2'd0;
  localparam logic [1:0] OP_LOCK = 2'd1;
  localparam logic [1:0] OP_PROG = 2'd2;

  typedef struct {
    logic [1:0] op;
    logic [7:0] code;
    logic       exp_type;
    logic       exp_unl;
    logic [1:0] exp_fail;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ncyc;
    int n;

    vecs[0] = '{OP_CODE, 8'h1B, 1'b1, 1'b1, 2'd0};
    vecs[1] = '{OP_LOCK, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[2] = '{OP_CODE, 8'h00, 1'b0, 1'b0, 2'd1};
    vecs[3] = '{OP_CODE, 8'h55, 1'b0, 1'b0, 2'd2};
    vecs[4] = '{OP_CODE, 8'h1B, 1'b1, 1'b1, 2'd0};
    vecs[5] = '{OP_PROG, 8'h1A, 1'b1, 1'b1, 2'd0};
    vecs[6] = '{OP_LOCK, 8'h00, 1'b0, 1'b0, 2'd0};
    vecs[7] = '{OP_CODE, 8'h1B, 1'b0, 1'b0, 2'd1};
    vecs[8] = '{OP_CODE, 8'h1A, 1'b1, 1'b1, 2'd0};
    vecs[9] = '{OP_LOCK, 8'h00, 1'b0, 1'b0, 2'd0};

    repeat (2) @(negedge hwclk);
    check("reset_outputs",
          {unlocked, programming, busy, fail_count, timeout_err, bif.start_blinking, bif.blinkType}, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      case (vecs[i].op)
        OP_CODE: begin
          enter_code(vecs[i].code);
          run_blink(vecs[i].exp_type, 1'b0, 1'b1, ncyc);
          check("arm_len", ncyc, 22);
          @(negedge hwclk);
          check("idle_busy", busy, 0);
        end
        OP_PROG: begin
          prog_req = 1'b1;
          @(negedge hwclk);
          prog_req = 1'b0;
          check("prog_enter", programming, 1);
          enter_code(vecs[i].code);
          run_blink(vecs[i].exp_type, 1'b0, 1'b1, ncyc);
          check("prog_done", programming, 0);
          @(negedge hwclk);
          check("idle_busy", busy, 0);
        end
        default: pulse_lock();
      endcase
      check("vec_unlocked", unlocked, vecs[i].exp_unl);
      check("vec_fail", fail_count, vecs[i].exp_fail);
    end

    // Key pressed mid-blink must be dropped, not counted.
    enter_code(8'h00);
    run_blink(1'b0, 1'b1, 1'b1, ncyc);
    @(negedge hwclk);
    check("drop_fail", fail_count, 1);
    press(2'd2); press(2'd2); press(2'd1);
    repeat (5) @(negedge hwclk);
    check("drop_no_compare", busy, 0);
    press(2'd0);
    run_blink(1'b1, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    check("drop_unlocked", unlocked, 1);
    check("drop_fail_clr", fail_count, 0);
    pulse_lock();

    // Three mismatches lead to a lockout that ignores all inputs.
    enter_code(8'h00);
    run_blink(1'b0, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    enter_code(8'h55);
    run_blink(1'b0, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    enter_code(8'hFF);
    run_blink(1'b0, 1'b0, 1'b1, ncyc);
    check("lockout_fail3", fail_count, 3);
    n = 0;
    for (int c = 0; c < 300; c++) begin
      key_valid = 1'b1;
      key_code  = 2'(c);
      lock_req  = (c % 7 == 0);
      prog_req  = (c % 5 == 0);
      @(negedge hwclk);
      if (!busy) break;
      n++;
    end
    key_valid = 1'b0; lock_req = 1'b0; prog_req = 1'b0;
    check("lockout_len", n, 100);
    check("lockout_fail_clr", fail_count, 0);
    check("lockout_locked", {unlocked, programming}, 0);
    enter_code(8'h1A);
    run_blink(1'b1, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    check("after_lockout_unl", unlocked, 1);

    // prog_req and lock_req together: lock wins.
    prog_req = 1'b1; lock_req = 1'b1;
    @(negedge hwclk);
    prog_req = 1'b0; lock_req = 1'b0;
    check("both_req", {unlocked, programming}, 0);
    enter_code(8'h1A);
    run_blink(1'b1, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    check("both_relock_ok", unlocked, 1);

    // Programming aborted by lock_req keeps the old code.
    prog_req = 1'b1;
    @(negedge hwclk);
    prog_req = 1'b0;
    press(2'd1); press(2'd1);
    pulse_lock();
    check("abort", {unlocked, programming}, 0);
    enter_code(8'h1A);
    run_blink(1'b1, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    check("abort_old_code", unlocked, 1);

    // Blinker never completes: timeout releases the request.
    pulse_lock();
    stuck = 1'b1;
    enter_code(8'h1A);
    run_blink(1'b1, 1'b0, 1'b0, ncyc);
    check("timeout_len", ncyc, 51);
    check("timeout_err_set", timeout_err, 1);
    @(negedge hwclk);
    check("timeout_unlocked", unlocked, 1);
    stuck = 1'b0;
    repeat (5) @(negedge hwclk);
    check("timeout_sticky", timeout_err, 1);

    // Reset mid-handshake drops start immediately and restores the reset code.
    pulse_lock();
    enter_code(8'h1A);
    n = 0;
    while (!(bif.start_blinking && !bif.done_blinking) && n < 50) begin
      @(negedge hwclk);
      n++;
    end
    check("reach_wait", bif.start_blinking && !bif.done_blinking, 1);
    @(negedge hwclk);
    rst = 1'b1;
    @(negedge hwclk);
    check("rst_mid_start", bif.start_blinking, 0);
    check("rst_mid_outputs", {unlocked, programming, busy, fail_count, timeout_err, bif.blinkType}, 0);
    rst = 1'b0;
    enter_code(8'h1B);
    run_blink(1'b1, 1'b0, 1'b1, ncyc);
    @(negedge hwclk);
    check("rst_code_restored", unlocked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lock_blink_controller.md
Name: lock_blink_controller

Overview:
Digital-lock sequencer on the initiator side of the LED blink handshake. It collects keypad digits and compares them against a stored code, then asks the LED blinker for a success blink (blinkType=1) or an error blink (blinkType=0). It drives start_blinking/blinkType and consumes done_blinking. It also handles code reprogramming while unlocked, and a lockout after repeated failures.

Parameters:
CODE_LEN, 4, number of digits per code
DIGIT_W, 2, bits per digit (4 keys)
RESET_CODE, 8'b00_01_10_11, code loaded on rst (digit0 in LSBs)
MAX_FAILS, 3, consecutive mismatches before lockout
LOCKOUT_CYCLES, 32'd120000000, lockout duration (10 s @ 12 MHz)
DONE_TIMEOUT, 32'd48000000, max cycles to wait for blinker done (4 s)

Ports:
hwclk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle pulse, digit available
key_code  in  DIGIT_W  digit value, qualified by key_valid
prog_req  in  1  one-cycle pulse, enter program mode (honoured only when unlocked)
lock_req  in  1  one-cycle pulse, relock
blinkType  out  1  0=error, 1=success; to blinker
start_blinking  out  1  level request to blinker
done_blinking  in  1  blinker completion level
unlocked  out  1  lock open
programming  out  1  collecting a new code
busy  out  1  blink handshake or lockout in progress; keys ignored
fail_count  out  2  consecutive mismatches, saturating
timeout_err  out  1  sticky: blinker never completed

Behaviour:
- Reset values (rst=1, takes effect at the next hwclk edge):
  - all outputs 0, including start_blinking and blinkType.
  - stored code = RESET_CODE; digit count = 0; main FSM = LOCKED.
  - rst mid-handshake drops start_blinking the next cycle.
- Main FSM: LOCKED, UNLOCKED, PROGRAM, BLINK, LOCKOUT.
- LOCKED:
  - Each key_valid while not busy shifts the digit into the entry register at index count, then count++.
  - When count reaches CODE_LEN, compare the entry with the stored code in the next cycle:
    - match: unlocked=1, fail_count=0, request success blink.
    - mismatch: fail_count++ (saturate at 3), request error blink.
  - After any comparison, clear count.
- BLINK: runs the handshake sub-FSM, then returns:
  - to UNLOCKED if unlocked=1;
  - to LOCKOUT if fail_count==MAX_FAILS;
  - otherwise to LOCKED.
- LOCKOUT:
  - busy=1; count LOCKOUT_CYCLES.
  - Then fail_count=0 and go to LOCKED.
  - key_valid, prog_req and lock_req are ignored throughout.
- UNLOCKED:
  - key_valid is ignored.
  - lock_req: unlocked=0, count=0, go to LOCKED.
  - prog_req: programming=1, count=0, go to PROGRAM.
  - prog_req and lock_req in the same cycle: lock_req wins.
- PROGRAM:
  - Collect CODE_LEN digits into the entry register.
  - Then copy the entry to the stored code, programming=0, request success blink, return to UNLOCKED.
  - lock_req aborts: old code kept, programming=0, go to LOCKED.
- Handshake sub-FSM (blinker latches blinkType on the rising edge of start_blinking; its done is stale for one cycle after that edge):
  - B_SETUP: drive blinkType, start_blinking=0, for 1 cycle.
  - B_ARM: start_blinking=1; wait until done_blinking==0.
  - B_WAIT: wait until done_blinking==1.
  - B_RELEASE: start_blinking=0 for 1 cycle; return to the main FSM.
- blinkType stays stable from B_SETUP until the next request.
- busy=1 from B_SETUP through B_RELEASE inclusive.
- Timeout:
  - The cycle counter runs in B_ARM and B_WAIT.
  - Reaching DONE_TIMEOUT sets timeout_err=1 (sticky until rst) and exits via B_RELEASE.
- Keys arriving while busy are dropped, not queued.
- Width rules:
  - Counters are 32-bit unsigned, cleared on every state entry.
  - count width is clog2(CODE_LEN+1).

Decomposition:
- Package lock_pkg:
  - main-state and handshake-state encodings.
  - BLINK_ERROR=1'b0, BLINK_SUCCESS=1'b1.
  - CODE_W = CODE_LEN*DIGIT_W.
- One sub-module, blink_requester:
  - Inputs: req pulse, req_type.
  - Outputs: start_blinking, blinkType, ack pulse, timeout pulse.
  - Timer: DONE_TIMEOUT.
  - Instantiated once by lock_blink_controller.

Test Plan:
1. rst held 2 cycles -> all outputs 0; stored code=8'b00_01_10_11.
2. Keys 3,2,1,0 (digit0=3? no: enter digit0=3,digit1=2,digit2=1,digit3=0 matching RESET_CODE) with a behavioural blinker (done low 1 cycle after start rises, high 20 cycles later) -> blinkType=1 held from B_SETUP; start rises 1 cycle after B_SETUP; start falls 1 cycle after done=1; unlocked=1; busy=0.
3. Keys 0,0,0,0 -> blinkType=0; unlocked=0; fail_count=1. Key pulse during busy -> count unchanged.
4. LOCKOUT_CYCLES=100; three wrong codes -> busy=1 for 100 cycles; keys ignored; then fail_count=0 and a correct code unlocks.
5. Unlocked; prog_req; keys 2,2,1,0; success blink; lock_req -> new code unlocks, RESET_CODE gives an error blink. prog_req+lock_req in the same cycle -> LOCKED.
6. DONE_TIMEOUT=50; blinker done stuck 1 -> start drops 51 cycles after rising; timeout_err=1 until rst. rst asserted in B_WAIT -> start_blinking=0 the next cycle.
